gb_lcd_capture: RTL and testbench
=================================

GB_LCD_CAPTURE -- requirements
Module: gb_lcd_capture

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive equal synchronized samples needed to change a filtered control state.
REQ-002 Parameter DATA_DELAY, default 5: clocks of delay applied to synchronized idata before write capture.
REQ-003 Parameter FRAME_PIX, default 23040: pixels per Game Boy frame (160x144).
REQ-004 clk  in  1  pixel/master clock (40 MHz PLL output); sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronous to clk.
REQ-006 idata  in  2  raw GB LCD pixel data, asynchronous to clk.
REQ-007 iclk  in  1  raw GB LCD pixel clock, asynchronous.
REQ-008 ihsync  in  1  raw GB LCD line sync, asynchronous.
REQ-009 ivsync  in  1  raw GB LCD frame sync, asynchronous.
REQ-010 wr_en  out  1  framebuffer write strobe, one cycle per captured pixel.
REQ-011 wr_addr  out  15  framebuffer write address, linear, 0..FRAME_PIX-1.
REQ-012 wr_data  out  2  framebuffer write data, inverted GB shade.
REQ-013 frame_start  out  1  one-cycle pulse on filtered ivsync rising edge.
REQ-014 frame_done  out  1  one-cycle pulse, coincident with the write to address FRAME_PIX-1.
REQ-015 overflow  out  1  sticky flag: a pixel event occurred with pixel counter >= FRAME_PIX.

Function
REQ-016 iclk, ihsync, ivsync, and idata SHALL each pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-017 Each control signal SHALL keep a filtered state; at an edge, the state toggles iff s2 and the previous FILTER_LEN-1 s2 samples all differ from it.
REQ-018 Latency: a raw level stable from edge 1 (first sampling edge) SHALL update the filtered state, and any resulting wr_en/pulse, at edge 6 with default parameters.
REQ-019 Synchronized idata SHALL be delayed DATA_DELAY further clocks; the capture value is ~(delayed idata) at the event edge.
REQ-020 Events: clk_fall = filtered iclk 1->0; hs_fall = filtered ihsync 1->0; vs_rise = filtered ivsync 0->1.
REQ-021 A pixel event SHALL be either hs_fall, or clk_fall while filtered ihsync is 0 (registered value, before any same-edge update).
REQ-022 On a pixel event with ipixel < FRAME_PIX: wr_en=1, wr_addr=ipixel, wr_data=capture value, ipixel<=ipixel+1; all three outputs registered.
REQ-023 clk_fall and hs_fall on the same edge SHALL produce exactly one write and one increment.
REQ-024 On a pixel event with ipixel >= FRAME_PIX: no write, no increment, overflow<=1.
REQ-025 frame_done SHALL pulse on the edge that writes address FRAME_PIX-1.
REQ-026 vs_rise SHALL set ipixel<=0, pulse frame_start, and clear overflow; it overrides a same-edge increment, and a same-edge pixel event SHALL still write at the pre-reset address.
REQ-027 wr_addr and wr_data SHALL hold their last values while wr_en=0.
REQ-028 Pixel events before the first vs_rise SHALL write starting at address 0.

Reset
REQ-029 During reset: wr_en, frame_start, frame_done, and overflow = 0; wr_addr = 0; wr_data = 0; ipixel = 0.
REQ-030 During reset: all synchronizer, history, delay, and filtered-state flops = 0.
REQ-031 Reset asserted mid-frame SHALL abort any pending write within the same cycle; after release, capture resumes at address 0.

Verification
REQ-032 Release reset, ivsync 0->1 held 10 clks -> frame_start pulses once at edge 6; ipixel=0.
REQ-033 ihsync 1->0 (iclk held high) with idata=2'b01 for >=10 clks prior -> one wr_en, wr_addr=0, wr_data=2'b10.
REQ-034 Then 159 iclk low pulses (each level held 8 clks), idata=2'b11 -> 159 writes at addr 1..159, data 2'b00; no write on iclk rising edges.
REQ-035 1- to 3-clk glitches on iclk/ihsync/ivsync -> no wr_en, no frame_start; filtered states unchanged.
REQ-036 Full frame of 144 lines -> frame_done coincides with wr_addr=23039; one extra iclk fall -> no write, overflow=1; next vs_rise -> overflow=0.
REQ-037 rst_n asserted mid-line, then released -> outputs at reset values immediately; next pixel event writes addr 0.

Source files
------------

// File: rtl/gb_lcd_capture.sv
// rtl/gb_lcd_capture.sv - Game Boy LCD bus capture into a linear framebuffer write port
module gb_lcd_capture #(
    parameter int FILTER_LEN = 4,
    parameter int DATA_DELAY = 5,
    parameter int FRAME_PIX  = 23040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  idata,
    input  logic        iclk,
    input  logic        ihsync,
    input  logic        ivsync,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [1:0]  wr_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        overflow
);
    localparam logic [14:0] FRAME_LIM = 15'(FRAME_PIX);
    localparam logic [14:0] LAST_PIX  = 15'(FRAME_PIX - 1);

    // control bit order: [0] iclk, [1] ihsync, [2] ivsync
    logic [2:0]  c_s1, c_s2, filt, flip;
    logic [2:0]  hist [FILTER_LEN-1];
    logic [1:0]  d_s1, d_s2;
    logic [1:0]  dly [DATA_DELAY];
    logic [14:0] ipixel;
    logic        clk_fall, hs_fall, vs_rise, pix_ev, do_write;

    // a filtered state flips only when the current and all remembered samples disagree with it
    always_comb begin
        flip = c_s2 ^ filt;
        for (int k = 0; k < FILTER_LEN - 1; k++) begin
            flip = flip & (hist[k] ^ filt);
        end
        clk_fall = filt[0] & flip[0];
        hs_fall  = filt[1] & flip[1];
        vs_rise  = ~filt[2] & flip[2];
        pix_ev   = hs_fall | (clk_fall & ~filt[1]);
        do_write = pix_ev & (ipixel < FRAME_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_s1 <= '0;
            c_s2 <= '0;
            filt <= '0;
            d_s1 <= '0;
            d_s2 <= '0;
            for (int k = 0; k < FILTER_LEN - 1; k++) hist[k] <= '0;
            for (int k = 0; k < DATA_DELAY; k++) dly[k] <= '0;
        end else begin
            c_s1 <= {ivsync, ihsync, iclk};
            c_s2 <= c_s1;
            filt <= filt ^ flip;
            d_s1 <= idata;
            d_s2 <= d_s1;
            hist[0] <= c_s2;
            for (int k = 1; k < FILTER_LEN - 1; k++) hist[k] <= hist[k-1];
            dly[0] <= d_s2;
            for (int k = 1; k < DATA_DELAY; k++) dly[k] <= dly[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            ipixel      <= '0;
        end else begin
            wr_en       <= do_write;
            frame_start <= vs_rise;
            frame_done  <= do_write && (ipixel == LAST_PIX);
            if (do_write) begin
                wr_addr <= ipixel;
                wr_data <= ~dly[DATA_DELAY-1];
            end
            // frame sync wins over a same-edge increment; the write above still uses the old address
            if (vs_rise) begin
                ipixel   <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_write) ipixel <= ipixel + 15'd1;
                if (pix_ev && !do_write) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gb_lcd_capture.sv
// tb/tb_gb_lcd_capture.sv - scoreboard bench for gb_lcd_capture
module tb_gb_lcd_capture;
    localparam int FP = 480;
    localparam int H  = 8;

    logic        clk, rst_n, iclk, ihsync, ivsync;
    logic [1:0]  idata;
    logic        wr_en, frame_start, frame_done, overflow;
    logic [14:0] wr_addr;
    logic [1:0]  wr_data;

    typedef struct {
        logic [14:0] a;
        logic [1:0]  d;
        logic        fd;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    int          fs_cnt = 0;
    int          exp_pix = 0;
    logic [14:0] last_a = '0;
    logic [1:0]  last_d = '0;

    gb_lcd_capture #(.FILTER_LEN(4), .DATA_DELAY(5), .FRAME_PIX(FP)) dut (
        .clk(clk), .rst_n(rst_n), .idata(idata), .iclk(iclk), .ihsync(ihsync),
        .ivsync(ivsync), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start), .frame_done(frame_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_px(input logic [1:0] d);
        exp_t e;
        if (exp_pix < FP) begin
            e.a  = 15'(exp_pix);
            e.d  = ~d;
            e.fd = (exp_pix == FP - 1);
            sb.push_back(e);
            exp_pix++;
        end
    endtask

    task automatic pixel(input logic [1:0] d);
        idata = d;
        step(H);
        iclk = 1'b0;
        expect_px(d);
        step(H);
        iclk = 1'b1;
    endtask

    task automatic line_start(input logic [1:0] d);
        idata = d;
        step(H + 4);
        ihsync = 1'b0;
        expect_px(d);
        step(H);
    endtask

    task automatic line_end();
        step(H);
        ihsync = 1'b1;
        step(H);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = '0;
            last_d = '0;
        end else begin
            if (frame_start) fs_cnt++;
            if (wr_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wr", 32'(wr_en), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.a));
                    chk("wr_data", 32'(wr_data), 32'(e.d));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                    last_a = e.a;
                    last_d = e.d;
                end
            end else begin
                chk("hold_addr", 32'(wr_addr), 32'(last_a));
                chk("hold_data", 32'(wr_data), 32'(last_d));
                chk("done_idle", 32'(frame_done), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edge_at, n_fs;
        logic [1:0] d;
        rst_n = 1'b0; iclk = 1'b1; ihsync = 1'b1; ivsync = 1'b0; idata = 2'b00;
        step(5);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step(20);

        // frame sync latency
        ivsync = 1'b1;
        edge_at = 0;
        n_fs = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (frame_start) begin
                n_fs++;
                if (edge_at == 0) edge_at = k;
            end
        end
        chk("fs_edge", 32'(edge_at), 32'd6);
        chk("fs_once", 32'(n_fs), 32'd1);

        // line 0: hs fall pixel with data 01, then iclk pixels with glitches mid-line
        line_start(2'b01);
        for (int p = 0; p < 4; p++) pixel(2'b11);
        for (int g = 1; g <= 3; g++) begin
            iclk = 1'b0; step(g); iclk = 1'b1; step(H);
            ihsync = 1'b1; step(g); ihsync = 1'b0; step(H);
            ivsync = 1'b0; step(g); ivsync = 1'b1; step(H);
        end
        chk("glitch_fs", 32'(fs_cnt), 32'd1);
        for (int p = 4; p < 159; p++) pixel(2'b11);
        line_end();

        // remaining lines up to the frame limit, random shades
        for (int l = 1; l < FP / 160; l++) begin
            d = 2'($urandom_range(0, 3));
            line_start(d);
            for (int p = 0; p < 159; p++) begin
                d = 2'($urandom_range(0, 3));
                pixel(d);
            end
            if (l == FP / 160 - 1) begin
                chk("pre_ovf", 32'(overflow), 32'd0);
                pixel(2'b10);
                step(10);
                chk("overflow_set", 32'(overflow), 32'd1);
            end
            line_end();
        end
        chk("frame_drained", 32'(sb.size()), 32'd0);

        ivsync = 1'b0; step(H);
        ivsync = 1'b1; step(12);
        exp_pix = 0;
        chk("overflow_clr", 32'(overflow), 32'd0);
        chk("fs_frame2", 32'(fs_cnt), 32'd2);

        // reset mid-line with an iclk fall still in the filter
        line_start(2'b00);
        pixel(2'b01);
        pixel(2'b10);
        idata = 2'b11; step(H);
        iclk = 1'b0; step(3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_fs", 32'(frame_start), 32'd0);
        chk("mid_rst_drained", 32'(sb.size()), 32'd0);
        exp_pix = 0;
        step(4);
        iclk = 1'b1;
        rst_n = 1'b1;
        step(20);
        pixel(2'b01);
        step(12);
        chk("post_rst_drained", 32'(sb.size()), 32'd0);
        chk("fs_total", 32'(fs_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
